// File: rtl/uart_baud_pkg.sv
// Shared constants for the UART baud-rate tick generator.
package uart_baud_pkg;

  localparam int unsigned DEF_DIV_W      = 16;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned OS_W           = $clog2(DEF_OVERSAMPLE);
  localparam int unsigned BAUD_DIV_MIN   = 1;

endpackage

// File: rtl/uart_baud_tick_gen_div_counter.sv
// Cycle counter with >= terminal compare against the effective divisor.
module baud_div_counter
  import uart_baud_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] baud_div,
  output logic [DIV_W-1:0] div_count,
  output logic             terminal_c
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_eff_div;
  logic [DIV_W-1:0] w_last;

  // Divisors below the minimum collapse to one clock per period.
  assign w_eff_div  = (baud_div <= DIV_W'(BAUD_DIV_MIN)) ? DIV_W'(BAUD_DIV_MIN) : baud_div;
  assign w_last     = w_eff_div - DIV_W'(1);
  assign terminal_c = (r_count >= w_last);

  always_ff @(posedge clk) begin
    if (rst || clr || terminal_c) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

  assign div_count = r_count;

endmodule

// File: rtl/uart_baud_tick_gen.sv
// Baud tick generator: 16x oversample tick every baud_div clocks, 1x tick every OVERSAMPLE-th.
// Optional BAUD_RESYNC_EN adds a resync input that realigns both counters like a reset.
module uart_baud_tick_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned DIV_W      = DEF_DIV_W,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  output logic             baud_tick_16x,
  output logic             baud_tick_1x,
  output logic [DIV_W-1:0] div_count
`ifdef BAUD_RESYNC_EN
  ,
  input  logic             resync
`endif
);

  localparam int unsigned OS_CNT_W = $clog2(OVERSAMPLE);

  logic                r_tick_16x;
  logic                r_tick_1x;
  logic [OS_CNT_W-1:0] r_os_count;
  logic                w_terminal;
  logic                w_resync;
  logic                w_os_last;

`ifdef BAUD_RESYNC_EN
  assign w_resync = resync;
`else
  assign w_resync = 1'b0;
`endif

  baud_div_counter #(
    .DIV_W (DIV_W)
  ) u_div_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_resync),
    .baud_div   (baud_div),
    .div_count  (div_count),
    .terminal_c (w_terminal)
  );

  assign w_os_last = (r_os_count == OS_CNT_W'(OVERSAMPLE - 1));

  // Oversample counter and registered tick stage; resync behaves as a local reset.
  always_ff @(posedge clk) begin
    if (rst || w_resync) begin
      r_os_count <= '0;
      r_tick_16x <= 1'b0;
      r_tick_1x  <= 1'b0;
    end else begin
      r_tick_16x <= w_terminal;
      r_tick_1x  <= w_terminal && w_os_last;
      if (w_terminal) begin
        r_os_count <= r_os_count + OS_CNT_W'(1);
      end
    end
  end

  assign baud_tick_16x = r_tick_16x;
  assign baud_tick_1x  = r_tick_1x;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Self-checking bench for uart_baud_tick_gen against a period/tick-count reference model.
module tb_uart_baud_tick_gen;

  localparam int DW = 16;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] baud_div = 16'd32;
  logic          baud_tick_16x;
  logic          baud_tick_1x;
  logic [DW-1:0] div_count;
`ifdef BAUD_RESYNC_EN
  logic          resync = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: clocks elapsed in the current period and 16x ticks since alignment.
  int   m_elapsed = 0;
  int   m_ticks = 0;
  logic m16 = 1'b0;
  logic m1 = 1'b0;

  uart_baud_tick_gen dut (
    .clk           (clk),
    .rst           (rst),
    .baud_div      (baud_div),
    .baud_tick_16x (baud_tick_16x),
    .baud_tick_1x  (baud_tick_1x),
    .div_count     (div_count)
`ifdef BAUD_RESYNC_EN
    ,
    .resync        (resync)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; the model applies the period rules to the inputs the DUT just sampled.
  task automatic step();
    bit clr;
    int eff;
    @(posedge clk);
    cyc++;
    clr = rst;
`ifdef BAUD_RESYNC_EN
    clr = clr | resync;
`endif
    eff = (baud_div < 2) ? 1 : int'(baud_div);
    if (clr) begin
      m_elapsed = 0; m_ticks = 0; m16 = 1'b0; m1 = 1'b0;
    end else if (m_elapsed + 1 >= eff) begin
      m16 = 1'b1;
      m1 = ((m_ticks % OS) == OS - 1);
      m_ticks++;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
      m16 = 1'b0; m1 = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    int first = -1;
    rst = 1'b1; baud_div = 16'd32;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (div_count !== 16'd0 || baud_tick_16x !== 1'b0 || baud_tick_1x !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got cnt=%0d 16x=%b 1x=%b exp cnt=0 16x=0 1x=0",
                 cyc, div_count, baud_tick_16x, baud_tick_1x);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      vectors++;
      if (baud_tick_16x !== m16 || baud_tick_1x !== m1 || div_count !== 16'(m_elapsed)) begin
        miscompares++;
        $display("FAIL reset_model cyc=%0d got 16x=%b 1x=%b cnt=%0d exp 16x=%b 1x=%b cnt=%0d",
                 cyc, baud_tick_16x, baud_tick_1x, div_count, m16, m1, m_elapsed);
      end
      if (baud_tick_16x === 1'b1 && first < 0) first = i;
    end
    vectors++;
    if (first !== 32) begin
      miscompares++;
      $display("FAIL reset_first_tick got %0d clks exp 32", first);
    end
  endtask

  task automatic test_periodicity();
    int last16 = -1;
    int last1 = -1;
    int n1 = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      vectors++;
      if (baud_tick_16x !== m16 || baud_tick_1x !== m1 || div_count !== 16'(m_elapsed)) begin
        miscompares++;
        $display("FAIL period_model cyc=%0d got 16x=%b 1x=%b cnt=%0d exp 16x=%b 1x=%b cnt=%0d",
                 cyc, baud_tick_16x, baud_tick_1x, div_count, m16, m1, m_elapsed);
      end
      if (baud_tick_16x === 1'b1) begin
        if (last16 >= 0) begin
          vectors++;
          if (cyc - last16 !== 32) begin
            miscompares++;
            $display("FAIL period_16x_spacing got %0d exp 32", cyc - last16);
          end
        end
        last16 = cyc;
      end
      if (baud_tick_1x === 1'b1) begin
        n1++;
        vectors++;
        if (baud_tick_16x !== 1'b1 || (last1 >= 0 && cyc - last1 !== 512)) begin
          miscompares++;
          $display("FAIL period_1x got spacing=%0d 16x=%b exp spacing=512 16x=1",
                   (last1 >= 0) ? cyc - last1 : 512, baud_tick_16x);
        end
        last1 = cyc;
      end
    end
    vectors++;
    if (n1 < 3) begin
      miscompares++;
      $display("FAIL period_1x_count got %0d exp >=3", n1);
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] divs [3];
    divs[0] = 16'd0; divs[1] = 16'd1; divs[2] = 16'd2;
    for (int d = 0; d < 3; d++) begin
      int n16 = 0;
      int n1 = 0;
      baud_div = divs[d];
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 64; i++) begin
        step();
        vectors++;
        if (baud_tick_16x !== m16 || baud_tick_1x !== m1 || div_count !== 16'(m_elapsed)) begin
          miscompares++;
          $display("FAIL boundary_model div=%0d cyc=%0d got 16x=%b 1x=%b cnt=%0d exp 16x=%b 1x=%b cnt=%0d",
                   baud_div, cyc, baud_tick_16x, baud_tick_1x, div_count, m16, m1, m_elapsed);
        end
        if (baud_tick_16x === 1'b1) n16++;
        if (baud_tick_1x === 1'b1) n1++;
      end
      vectors++;
      if (n16 !== ((d < 2) ? 64 : 32) || n1 !== ((d < 2) ? 4 : 2)) begin
        miscompares++;
        $display("FAIL boundary_counts div=%0d got n16=%0d n1=%0d exp n16=%0d n1=%0d",
                 baud_div, n16, n1, (d < 2) ? 64 : 32, (d < 2) ? 4 : 2);
      end
    end
  endtask

  task automatic test_div_change();
    int last = -1;
    int i;
    baud_div = 16'd32;
    rst = 1'b1; step(); rst = 1'b0;
    i = 0;
    while (div_count !== 16'd20 && i < 100) begin step(); i++; end
    vectors++;
    if (div_count !== 16'd20) begin
      miscompares++;
      $display("FAIL change_wait got cnt=%0d exp 20", div_count);
    end
    baud_div = 16'd8;
    step();
    vectors++;
    if (baud_tick_16x !== 1'b1 || div_count !== 16'd0) begin
      miscompares++;
      $display("FAIL change_down_tick got 16x=%b cnt=%0d exp 16x=1 cnt=0", baud_tick_16x, div_count);
    end
    last = cyc;
    for (int k = 0; k < 40; k++) begin
      step();
      vectors++;
      if (baud_tick_16x !== m16 || baud_tick_1x !== m1 || div_count !== 16'(m_elapsed)) begin
        miscompares++;
        $display("FAIL change_model cyc=%0d got 16x=%b 1x=%b cnt=%0d exp 16x=%b 1x=%b cnt=%0d",
                 cyc, baud_tick_16x, baud_tick_1x, div_count, m16, m1, m_elapsed);
      end
      if (baud_tick_16x === 1'b1) begin
        vectors++;
        if (cyc - last !== 8) begin
          miscompares++;
          $display("FAIL change_8_spacing got %0d exp 8", cyc - last);
        end
        last = cyc;
      end
    end
    i = 0;
    while (baud_tick_16x !== 1'b1 && i < 20) begin step(); i++; end
    last = cyc;
    baud_div = 16'd40;
    i = 0;
    do begin step(); i++; end while (baud_tick_16x !== 1'b1 && i < 100);
    vectors++;
    if (baud_tick_16x !== 1'b1 || cyc - last !== 40) begin
      miscompares++;
      $display("FAIL change_up_spacing got %0d exp 40", cyc - last);
    end
  endtask

  task automatic test_mid_reset();
    int bd;
    int i;
    bd = int'($urandom_range(3, 10));
    baud_div = 16'(bd);
    rst = 1'b1; step(); rst = 1'b0;
    i = 0;
    while (m_ticks != 7 && i < 200) begin step(); i++; end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++;
    if (div_count !== 16'd0 || baud_tick_16x !== 1'b0 || baud_tick_1x !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state got cnt=%0d 16x=%b 1x=%b exp cnt=0 16x=0 1x=0",
               div_count, baud_tick_16x, baud_tick_1x);
    end
    i = 0;
    do begin step(); i++; end while (baud_tick_1x !== 1'b1 && i < 16 * bd + 10);
    vectors++;
    if (i !== 16 * bd) begin
      miscompares++;
      $display("FAIL midreset_1x_latency div=%0d got %0d clks exp %0d", bd, i, 16 * bd);
    end
  endtask

`ifdef BAUD_RESYNC_EN
  task automatic test_resync();
    int i;
    int t16 = -1;
    baud_div = 16'd32;
    rst = 1'b1; step(); rst = 1'b0;
    i = 0;
    while (div_count !== 16'd17 && i < 100) begin step(); i++; end
    resync = 1'b1; step(); resync = 1'b0;
    vectors++;
    if (div_count !== 16'd0 || baud_tick_16x !== 1'b0 || baud_tick_1x !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_state got cnt=%0d 16x=%b 1x=%b exp cnt=0 16x=0 1x=0",
               div_count, baud_tick_16x, baud_tick_1x);
    end
    i = 0;
    do begin
      step(); i++;
      if (baud_tick_16x === 1'b1 && t16 < 0) t16 = i;
    end while (baud_tick_1x !== 1'b1 && i < 600);
    vectors++;
    if (t16 !== 32 || i !== 512) begin
      miscompares++;
      $display("FAIL resync_latency got 16x=%0d 1x=%0d exp 16x=32 1x=512", t16, i);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) baud_div = 16'($urandom_range(0, 40));
      rst = ($urandom_range(0, 199) == 0);
`ifdef BAUD_RESYNC_EN
      resync = ($urandom_range(0, 99) == 0);
`endif
      step();
      vectors++;
      if (baud_tick_16x !== m16 || baud_tick_1x !== m1 || div_count !== 16'(m_elapsed)) begin
        miscompares++;
        $display("FAIL random_model div=%0d cyc=%0d got 16x=%b 1x=%b cnt=%0d exp 16x=%b 1x=%b cnt=%0d",
                 baud_div, cyc, baud_tick_16x, baud_tick_1x, div_count, m16, m1, m_elapsed);
      end
    end
    rst = 1'b0;
`ifdef BAUD_RESYNC_EN
    resync = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_periodicity();
    test_boundary();
    test_div_change();
    test_mid_reset();
`ifdef BAUD_RESYNC_EN
    test_resync();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
